// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: opcodes, PC sequencer state encoding
// and the default reset vector.
package riscv_pkg;

  localparam logic [6:0]  OPC_JAL              = 7'b1101111;
  localparam logic [6:0]  OPC_JALR             = 7'b1100111;
  localparam logic [6:0]  OPC_BRANCH           = 7'b1100011;
  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0040_0000;

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_HALT
  } pc_state_t;

  // JALR drops bit 0 of the computed address; the add wraps modulo 2^32.
  function automatic logic [31:0] jalr_target(input logic [31:0] base,
                                              input logic [31:0] offset);
    return (base + offset) & ~32'h1;
  endfunction

endpackage

// File: rtl/npc_target_calc.sv
// Combinational jump/branch target computation for the PC sequencer,
// with a flag for targets that are not on a 4-byte boundary.
module npc_target_calc
  import riscv_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic [6:0]  i_opcode,
  input  logic [31:0] i_imm,
  input  logic [31:0] i_rs1Data,
  output logic [31:0] o_target,
  output logic        o_misaligned
);

  logic [31:0] w_target;

  // JALR is register-relative; every other taken transfer is PC-relative.
  always_comb begin
    w_target = i_pc + i_imm;
    if (i_opcode == OPC_JALR) begin
      w_target = jalr_target(i_rs1Data, i_imm);
    end
  end

  assign o_target     = w_target;
  assign o_misaligned = w_target[1];

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter register and next-PC FSM (BOOT/RUN/HALT).
// Optional statistics counters are built when PC_BRANCH_STATS_EN is defined.
module pc_sequencer
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter int          CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 branch_flag_i,
  input  logic [6:0]           opcode_i,
  input  logic [31:0]          imm_i,
  input  logic [31:0]          rs1_data_i,
  input  logic                 stall_i,
  input  logic                 restart_i,
  output logic [31:0]          pc_o,
  output logic [31:0]          pc_plus4_o,
  output logic                 fetch_valid_o,
  output logic                 misalign_o,
  output logic [31:0]          bad_addr_o,
  output logic [CNT_WIDTH-1:0] taken_cnt_o,
  output logic [CNT_WIDTH-1:0] instr_cnt_o
);

  pc_state_t   r_state;
  pc_state_t   w_stateNext;
  logic [31:0] r_pc;
  logic [31:0] w_pcNext;
  logic [31:0] w_pcPlus4;
  logic        r_misalign;
  logic        w_misalignNext;
  logic [31:0] r_badAddr;
  logic [31:0] w_badAddrNext;
  logic        w_fetchValid;
  logic [31:0] w_target;
  logic        w_targetMisaligned;

  assign w_pcPlus4 = r_pc + 32'd4;

  npc_target_calc u_targetCalc (
    .i_pc         (r_pc),
    .i_opcode     (opcode_i),
    .i_imm        (imm_i),
    .i_rs1Data    (rs1_data_i),
    .o_target     (w_target),
    .o_misaligned (w_targetMisaligned)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_BOOT;
      r_pc       <= RESET_VECTOR;
      r_misalign <= 1'b0;
      r_badAddr  <= 32'h0;
    end else begin
      r_state    <= w_stateNext;
      r_pc       <= w_pcNext;
      r_misalign <= w_misalignNext;
      r_badAddr  <= w_badAddrNext;
    end
  end

  always_comb begin
    w_stateNext    = r_state;
    w_pcNext       = r_pc;
    w_misalignNext = r_misalign;
    w_badAddrNext  = r_badAddr;
    w_fetchValid   = 1'b0;
    case (r_state)
      S_BOOT: begin
        w_stateNext = S_RUN;
      end
      S_RUN: begin
        w_fetchValid = 1'b1;
        if (!stall_i) begin
          // A bad taken target freezes the PC on the faulting instruction.
          if (branch_flag_i && w_targetMisaligned) begin
            w_stateNext    = S_HALT;
            w_misalignNext = 1'b1;
            w_badAddrNext  = w_target;
          end else begin
            w_pcNext = branch_flag_i ? w_target : w_pcPlus4;
          end
        end
      end
      S_HALT: begin
        if (restart_i) begin
          w_stateNext    = S_BOOT;
          w_pcNext       = RESET_VECTOR;
          w_misalignNext = 1'b0;
        end
      end
      default: begin
        w_stateNext = S_BOOT;
      end
    endcase
  end

  assign pc_o          = r_pc;
  assign pc_plus4_o    = w_pcPlus4;
  assign fetch_valid_o = w_fetchValid;
  assign misalign_o    = r_misalign;
  assign bad_addr_o    = r_badAddr;

`ifdef PC_BRANCH_STATS_EN
  logic                 w_advance;
  logic [CNT_WIDTH-1:0] r_instrCnt;
  logic [CNT_WIDTH-1:0] r_takenCnt;

  assign w_advance = (r_state == S_RUN) && !stall_i &&
                     !(branch_flag_i && w_targetMisaligned);

  // Both counters saturate rather than wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instrCnt <= '0;
      r_takenCnt <= '0;
    end else if (w_advance) begin
      if (r_instrCnt != '1) begin
        r_instrCnt <= r_instrCnt + 1'b1;
      end
      if (branch_flag_i && (r_takenCnt != '1)) begin
        r_takenCnt <= r_takenCnt + 1'b1;
      end
    end
  end

  assign instr_cnt_o = r_instrCnt;
  assign taken_cnt_o = r_takenCnt;
`else
  assign instr_cnt_o = '0;
  assign taken_cnt_o = '0;
`endif

endmodule
